// File: rtl/bounce_field_if.sv
// ---------------------------------------------------------------------------
// bounce_field_if
// Control and render bundle between the bounce_field engine and its user.
//   frame_tick    : one-cycle per-frame update request (user -> engine)
//   pause         : suppresses frame_tick while the engine is idle
//   video_active  : display-on from the sync generator
//   pix_x / pix_y : current pixel column / row
//   hit / hit_id  : registered pixel-inside-square flag and lowest square index
//   busy          : update in progress
//   bounce_pulse  : one-cycle pulse, a wall reflection happened this update
//   collide_pulse : one-cycle pulse, an overlapping pair was found this update
// master = user side (sync generator / testbench), slave = engine side.
// ---------------------------------------------------------------------------
interface bounce_field_if #(
   parameter int N_OBJ = 4
);
   localparam int ID_W = $clog2(N_OBJ);

   logic            frame_tick;
   logic            pause;
   logic            video_active;
   logic [9:0]      pix_x;
   logic [9:0]      pix_y;
   logic            hit;
   logic [ID_W-1:0] hit_id;
   logic            busy;
   logic            bounce_pulse;
   logic            collide_pulse;

   modport master (
      output frame_tick, pause, video_active, pix_x, pix_y,
      input  hit, hit_id, busy, bounce_pulse, collide_pulse
   );

   modport slave (
      input  frame_tick, pause, video_active, pix_x, pix_y,
      output hit, hit_id, busy, bounce_pulse, collide_pulse
   );
endinterface

// File: rtl/bounce_field.sv
// ---------------------------------------------------------------------------
// bounce_field
// N-object bouncing-square engine. Holds position/direction for N_OBJ squares
// and, on each accepted frame tick, walks a small FSM: MOVE advances one
// square per cycle with wall reflection, COLLIDE tests one unordered pair per
// cycle and pushes overlapping squares apart by steering their directions.
// In parallel a registered render path reports whether the current pixel is
// covered and by which (lowest-numbered) square.
// Ports:
//   clk   : pixel clock
//   reset : synchronous, active-high; restores the start layout
//   bus   : bounce_field_if.slave (frame_tick/pause in, pixel in,
//           hit/hit_id/busy/bounce_pulse/collide_pulse out)
// ---------------------------------------------------------------------------
module bounce_field #(
   parameter int N_OBJ   = 4,
   parameter int SIZE    = 40,
   parameter int SPEED   = 3,
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int COORD_W = 11
) (
   input  logic          clk,
   input  logic          reset,
   bounce_field_if.slave bus
);
   localparam int ID_W = $clog2(N_OBJ);
   // One spare bit so pos+SPEED and pos+SIZE can never wrap.
   localparam int W    = COORD_W + 1;

   localparam logic [W-1:0]    SPD    = W'(SPEED);
   localparam logic [W-1:0]    SZ     = W'(SIZE);
   localparam logic [W-1:0]    XMAX   = W'(H_RES - SIZE);
   localparam logic [W-1:0]    YMAX   = W'(V_RES - SIZE);
   localparam logic [ID_W-1:0] LAST   = ID_W'(N_OBJ - 1);
   localparam logic [ID_W-1:0] LAST_A = ID_W'(N_OBJ - 2);

   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_COLLIDE} state_e;

   typedef struct packed {
      logic [COORD_W-1:0] pos;
      logic               neg;   // 1 = moving left/up
      logic               wall;  // reflection happened
   } axis_t;

   state_e                        state_q, state_d;
   logic [ID_W-1:0]               idx_q, idx_d;  // MOVE object / COLLIDE pair 'a'
   logic [ID_W-1:0]               b_q, b_d;      // COLLIDE pair 'b'
   logic [N_OBJ-1:0][COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [N_OBJ-1:0]              dx_q, dx_d, dy_q, dy_d;
   logic                          bounce_q, bounce_d;
   logic                          collide_q, collide_d;
   logic                          bpulse_q, bpulse_d;
   logic                          cpulse_q, cpulse_d;
   logic                          hit_q, hit_d;
   logic [ID_W-1:0]               hid_q, hid_d;

   axis_t                         ax, ay;
   logic [W-1:0]                  xa, xb, ya, yb;
   logic                          ovl;
   logic [W-1:0]                  px, py;
   logic [N_OBJ-1:0]              in_sq;

   // One axis of the MOVE step: clamp to the wall and flip on reaching it.
   function automatic axis_t step_axis(logic [COORD_W-1:0] pos, logic neg,
                                       logic [W-1:0] lim);
      axis_t        r;
      logic [W-1:0] p;
      p      = {1'b0, pos};
      r.pos  = pos;
      r.neg  = neg;
      r.wall = 1'b0;
      if (!neg) begin
         if (p + SPD >= lim) begin
            r.pos  = lim[COORD_W-1:0];
            r.neg  = 1'b1;
            r.wall = 1'b1;
         end else begin
            r.pos = COORD_W'(p + SPD);
         end
      end else begin
         if (p <= SPD) begin
            r.pos  = '0;
            r.neg  = 1'b0;
            r.wall = 1'b1;
         end else begin
            r.pos = COORD_W'(p - SPD);
         end
      end
      return r;
   endfunction

   // Pair under test in COLLIDE; positions are stable during that phase.
   assign xa  = {1'b0, x_q[idx_q]};
   assign xb  = {1'b0, x_q[b_q]};
   assign ya  = {1'b0, y_q[idx_q]};
   assign yb  = {1'b0, y_q[b_q]};
   assign ovl = (xa < xb + SZ) && (xb < xa + SZ) &&
                (ya < yb + SZ) && (yb < ya + SZ);

   // ---------------- update FSM ----------------
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      b_d       = b_q;
      x_d       = x_q;
      y_d       = y_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      bounce_d  = bounce_q;
      collide_d = collide_q;
      bpulse_d  = 1'b0;
      cpulse_d  = 1'b0;
      ax        = '0;
      ay        = '0;
      case (state_q)
         S_IDLE: begin
            if (bus.frame_tick && !bus.pause) begin
               state_d   = S_MOVE;
               idx_d     = '0;
               bounce_d  = 1'b0;
               collide_d = 1'b0;
            end
         end
         S_MOVE: begin
            ax          = step_axis(x_q[idx_q], dx_q[idx_q], XMAX);
            ay          = step_axis(y_q[idx_q], dy_q[idx_q], YMAX);
            x_d[idx_q]  = ax.pos;
            y_d[idx_q]  = ay.pos;
            dx_d[idx_q] = ax.neg;
            dy_d[idx_q] = ay.neg;
            if (ax.wall || ay.wall) bounce_d = 1'b1;
            if (idx_q == LAST) begin
               state_d = S_COLLIDE;
               idx_d   = '0;
               b_d     = ID_W'(1);
            end else begin
               idx_d = idx_q + ID_W'(1);
            end
         end
         S_COLLIDE: begin
            if (ovl) begin
               collide_d = 1'b1;
               // Steer the left/upper square further left/up, the other away.
               if (xa < xb) begin
                  dx_d[idx_q] = 1'b1;
                  dx_d[b_q]   = 1'b0;
               end else if (xa > xb) begin
                  dx_d[idx_q] = 1'b0;
                  dx_d[b_q]   = 1'b1;
               end
               if (ya < yb) begin
                  dy_d[idx_q] = 1'b1;
                  dy_d[b_q]   = 1'b0;
               end else if (ya > yb) begin
                  dy_d[idx_q] = 1'b0;
                  dy_d[b_q]   = 1'b1;
               end
            end
            if (b_q == LAST) begin
               if (idx_q == LAST_A) begin
                  state_d  = S_IDLE;
                  bpulse_d = bounce_q;
                  cpulse_d = collide_d;  // include the final pair's result
               end else begin
                  idx_d = idx_q + ID_W'(1);
                  b_d   = idx_q + ID_W'(2);
               end
            end else begin
               b_d = b_q + ID_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- render path ----------------
   assign px = {{(W-10){1'b0}}, bus.pix_x};
   assign py = {{(W-10){1'b0}}, bus.pix_y};

   for (genvar i = 0; i < N_OBJ; i++) begin : g_sq
      assign in_sq[i] = (px >= {1'b0, x_q[i]}) && (px < {1'b0, x_q[i]} + SZ) &&
                        (py >= {1'b0, y_q[i]}) && (py < {1'b0, y_q[i]} + SZ);
   end

   always_comb begin
      hit_d = bus.video_active && (|in_sq);
      hid_d = '0;
      // Walk downwards so the lowest covering index wins.
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         if (in_sq[i]) hid_d = ID_W'(i);
      end
      if (!hit_d) hid_d = '0;
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         b_q       <= '0;
         bounce_q  <= 1'b0;
         collide_q <= 1'b0;
         bpulse_q  <= 1'b0;
         cpulse_q  <= 1'b0;
         hit_q     <= 1'b0;
         hid_q     <= '0;
         for (int i = 0; i < N_OBJ; i++) begin
            x_q[i]  <= COORD_W'(16 + 64 * i);
            y_q[i]  <= COORD_W'(16 + 48 * i);
            dx_q[i] <= 1'(i % 2);   // odd squares start left/up
            dy_q[i] <= 1'(i % 2);
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         b_q       <= b_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         bounce_q  <= bounce_d;
         collide_q <= collide_d;
         bpulse_q  <= bpulse_d;
         cpulse_q  <= cpulse_d;
         hit_q     <= hit_d;
         hid_q     <= hid_d;
      end
   end

   assign bus.busy          = (state_q != S_IDLE);
   assign bus.bounce_pulse  = bpulse_q;
   assign bus.collide_pulse = cpulse_q;
   assign bus.hit           = hit_q;
   assign bus.hit_id        = hid_q;

endmodule

// File: doc/bounce_field.md
# bounce_field

Parametrised N-object bouncing-square engine for the VGA demo path. It holds position and direction state for `N_OBJ` squares and advances them once per frame on a `frame_tick` pulse. A sequential FSM applies wall reflection, then pairwise separation. In parallel it renders a registered per-pixel hit and object index for the colour mapper downstream of `hvsync_generator`.

## Interface
- `N_OBJ`, 4: number of squares, range 2..8.
- `SIZE`, 40: square edge in pixels.
- `SPEED`, 3: pixels moved per frame per axis.
- `H_RES`, 640: visible width.
- `V_RES`, 480: visible height.
- `COORD_W`, 11: unsigned coordinate width for stored positions.

- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per frame, issued in vertical blanking.
- `pause` in 1: when high, `frame_tick` is ignored.
- `video_active` in 1: display-on from the sync generator.
- `pix_x` in 10: current pixel column.
- `pix_y` in 10: current pixel row.
- `hit` out 1: registered; the current pixel lies inside some square.
- `hit_id` out clog2(N_OBJ): registered index of the lowest-numbered square covering the pixel.
- `busy` out 1: high while an update is in progress.
- `bounce_pulse` out 1: one-cycle pulse; at least one wall reflection occurred this update.
- `collide_pulse` out 1: one-cycle pulse; at least one overlapping pair was found this update.

## Operation
- **Reset values.**
  - Square i: x = 16 + 64·i, y = 16 + 48·i.
  - dir_x = right for even i, left for odd i.
  - dir_y = down for even i, up for odd i.
  - All outputs are 0. FSM is in IDLE.
- **FSM states:** IDLE → MOVE → COLLIDE → IDLE.
- **IDLE.**
  - `frame_tick` with `pause`=0 → MOVE, object index 0.
  - The bounce and collide flags are cleared on this entry.
  - `frame_tick` in any other state, or with `pause`=1, is ignored and is not queued.
- **MOVE:** one object per cycle, index 0..N_OBJ-1, per axis.
  - Moving right/down with pos + SPEED ≥ LIMIT − SIZE (LIMIT = H_RES or V_RES): pos := LIMIT − SIZE, direction flips, bounce flag set.
  - Moving left/up with pos ≤ SPEED: pos := 0, direction flips, bounce flag set.
  - Otherwise pos := pos ± SPEED.
  - Both axes are evaluated independently in the same cycle.
  - Arithmetic is done in COORD_W+1 bits, so no wrap is possible.
- **COLLIDE:** one unordered pair (a<b) per cycle.
  - Order is lexicographic: (0,1),(0,2)…(N−2,N−1). P = N_OBJ·(N_OBJ−1)/2 cycles.
  - Overlap test: x_a < x_b+SIZE ∧ x_b < x_a+SIZE ∧ y_a < y_b+SIZE ∧ y_b < y_a+SIZE. Edge-touching squares do not overlap.
  - On overlap, per axis: if x_a < x_b then dir_x[a]:=left, dir_x[b]:=right. If x_a > x_b, the opposite. If equal, unchanged. Y is handled the same way with up/down. The collide flag is set.
  - Positions are not modified in COLLIDE.
  - Later pairs see directions already updated by earlier pairs.
- **Completion.**
  - After the last pair, the FSM returns to IDLE.
  - In that cycle `bounce_pulse` and `collide_pulse` equal their flags for exactly one cycle.
- **Render path.**
  - Every cycle: `hit` <= video_active ∧ ∃i: x_i ≤ pix_x < x_i+SIZE ∧ y_i ≤ pix_y < y_i+SIZE.
  - `hit_id` <= lowest such i, or 0 when `hit`=0.
  - The render path always uses the current register state, including during an update.

## Timing
- Tick sampled in cycle T:
  - `busy`=1 from T+1 through T+N_OBJ+P.
  - MOVE occupies T+1..T+N_OBJ; COLLIDE occupies T+N_OBJ+1..T+N_OBJ+P.
  - `busy`=0 and the pulses are valid at T+N_OBJ+P+1.
- Defaults (N=4, P=6): busy for 10 cycles; pulses at T+11.
- Render latency is exactly 1 cycle from `pix_x`/`pix_y`/`video_active` to `hit`/`hit_id`.
- Reset asserted mid-update restores all reset values on the next edge. No pulse is emitted.
- `pause` is sampled only in IDLE. Asserting it while busy does not abort the current update.

## Test plan
- **Reset:** hold `reset` 2 cycles, then drive pix=(16,16) with video_active=1 → next cycle `hit`=1, `hit_id`=0. Pix (80,16) → `hit`=0; square 1 starts at y=64.
- **Single tick from reset:**
  - `busy` is high for 10 cycles.
  - Square 0 moves to (19,19); square 1 moves to (77,61).
  - Both pulses stay 0.
- **Wall clamp:** force square 0 to x=598, moving right, and tick → x=600, dir_x=left, `bounce_pulse`=1 at T+11. Next tick → x=597.
- **Collision:** place square 0 at (100,100) moving right, square 1 at (130,110) moving left, others far apart. Tick →
  - `collide_pulse`=1.
  - Square 0 has dir_x=left, dir_y=up; square 1 has dir_x=right, dir_y=down.
- **Ignored ticks:**
  - A second `frame_tick` at T+3 leaves positions advanced exactly once.
  - A tick with `pause`=1 leaves `busy`=0 and all positions unchanged.
- **Priority and blanking:** overlap squares 1 and 2 on pixel (200,200).
  - With video_active=1 → `hit_id`=1.
  - With video_active=0 → `hit`=0, `hit_id`=0.
